ahb_sram_ctrl: RTL and testbench

- Parametrised AHB-Lite SRAM slave; next generation of the single-transfer on-chip SRAM port on the peripheral bus.
- Supports N banks of configurable depth and data widths of 32 or 64 bits.
- Supports SEQ/BUSY beats of every HBURST type, with zero-wait reads and zero-wait writes.
- Inserts exactly one wait state on a read-after-write port conflict; optional ERROR response for illegal transfers.

---
 rtl/ahb_sram_ctrl_pkg.sv | 22 ++
 rtl/ahb_sram_ctrl_if.sv | 18 +
 rtl/ahb_sram_ctrl_sram_sp_be.sv | 17 +
 rtl/ahb_sram_ctrl.sv | 97 +++++++++
 tb/tb_ahb_sram_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// ahb_pkg: AHB-Lite encodings and controller FSM states shared by the SRAM controller and its bench.
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;
   localparam logic [2:0] HSIZE_BYTE    = 3'd0;
   localparam logic [2:0] HSIZE_HALF    = 3'd1;
   localparam logic [2:0] HSIZE_WORD    = 3'd2;
   localparam logic [2:0] HSIZE_DWORD   = 3'd3;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_RAW, ST_ERR1, ST_ERR2} state_e;
endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// ahb_sram_ctrl_if: AHB-Lite slave-side bus bundle with master and slave views.
interface ahb_sram_ctrl_if #(parameter int AWIDTH = 32, parameter int DWIDTH = 32);
   logic              hsel_i;
   logic              hwrite_i;
   logic              hready_i;
   logic [2:0]        hsize_i;
   logic [2:0]        hburst_i;
   logic [1:0]        htrans_i;
   logic [DWIDTH-1:0] hwdata_i;
   logic [AWIDTH-1:0] haddr_i;
   logic              hreadyout_o;
   logic              hresp_o;
   logic [DWIDTH-1:0] hrdata_o;
   modport master (output hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, hwdata_i, haddr_i,
                   input hreadyout_o, hresp_o, hrdata_o);
   modport slave  (input hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, hwdata_i, haddr_i,
                   output hreadyout_o, hresp_o, hrdata_o);
endinterface

// File: rtl/ahb_sram_ctrl_sram_sp_be.sv
// sram_sp_be: single-port synchronous SRAM bank, active-low chip and per-byte write enables, 1-cycle read.
module sram_sp_be #(parameter int DW = 32, parameter int AW = 13) (
   input  logic            clk_i,
   input  logic            cen_n_i,
   input  logic [DW/8-1:0] wen_n_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   output logic [DW-1:0]   rdata_o
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk_i)
      if (!cen_n_i) begin
         for (int i = 0; i < DW/8; i++)
            if (!wen_n_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         if (&wen_n_i) rdata_o <= mem[addr_i];
      end
endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: banked AHB-Lite SRAM slave, zero-wait reads/writes, one wait on read-after-write.
// Define AHB_SRAM_ERR_EN to answer illegal transfers with a two-cycle ERROR.
module ahb_sram_ctrl import ahb_pkg::*; #(
   parameter int AWIDTH   = 32,
   parameter int DWIDTH   = 32,
   parameter int BANK_NUM = 2,
   parameter int BANK_AW  = 13
) (
   input logic           hclk,
   input logic           hresetn,
   ahb_sram_ctrl_if.slave bus
);
   localparam int LANES = DWIDTH / 8;
   localparam int LSB   = $clog2(LANES);
   localparam int BW    = $clog2(BANK_NUM);
   localparam int BSW   = BW > 0 ? BW : 1;
   state_e             state_q, state_d;
   logic               acc, ill, rd_acc, wr_acc, cen, we;
   logic [2:0]         sz;
   logic [LSB-1:0]     lane;
   logic [LANES-1:0]   mask, wr_mask_q;
   logic [BANK_AW-1:0] word, s_word, wr_word_q, rd_word_q;
   logic [BSW-1:0]     bank, s_bank, wr_bank_q, rd_bank_q, rsel_q;
   logic [DWIDTH-1:0]  rdata [BANK_NUM];
   logic               unused_bits;
   assign unused_bits = ^{bus.hburst_i, bus.haddr_i};
   assign acc  = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
   assign sz   = bus.hsize_i > 3'(LSB) ? 3'(LSB) : bus.hsize_i;
   assign lane = bus.haddr_i[LSB-1:0] & ~LSB'((1 << sz) - 1);
   assign word = bus.haddr_i[LSB +: BANK_AW];
   assign bank = BW == 0 ? '0 : BSW'(bus.haddr_i >> (LSB + BANK_AW));
   always_comb
      for (int i = 0; i < LANES; i++)
         mask[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << sz));
`ifdef AHB_SRAM_ERR_EN
   assign ill = (bus.hsize_i > 3'(LSB)) | (|(bus.haddr_i[LSB-1:0] & LSB'((1 << bus.hsize_i) - 1)))
              | ((bus.haddr_i >> (LSB + BANK_AW + BW)) != '0);
   assign bus.hresp_o = (state_q == ST_ERR1) | (state_q == ST_ERR2);
`else
   assign ill = 1'b0;
   assign bus.hresp_o = HRESP_OKAY;
`endif
   assign rd_acc = acc & ~ill & ~bus.hwrite_i;
   assign wr_acc = acc & ~ill & bus.hwrite_i;
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) state_q <= ST_IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q == ST_RAW  ? ST_RD :
                state_q == ST_ERR1 ? ST_ERR2 :
                !acc               ? ST_IDLE :
                ill                ? ST_ERR1 :
                bus.hwrite_i       ? ST_WR :
                state_q == ST_WR   ? ST_RAW : ST_RD;
      bus.hreadyout_o = !(state_q == ST_RAW || state_q == ST_ERR1);
      bus.hrdata_o = state_q == ST_RD ? rdata[rsel_q] : '0;
   end
   // The write data phase owns the port; a colliding read is parked and replayed in RAW.
   always_comb begin
      we     = state_q == ST_WR;
      cen    = hresetn & (we | state_q == ST_RAW | rd_acc);
      s_word = we ? wr_word_q : state_q == ST_RAW ? rd_word_q : word;
      s_bank = we ? wr_bank_q : state_q == ST_RAW ? rd_bank_q : bank;
   end
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) begin
         wr_word_q <= '0;
         wr_bank_q <= '0;
         wr_mask_q <= '0;
         rd_word_q <= '0;
         rd_bank_q <= '0;
         rsel_q    <= '0;
      end else begin
         if (wr_acc) begin
            wr_word_q <= word;
            wr_bank_q <= bank;
            wr_mask_q <= mask;
         end
         if (rd_acc) begin
            rd_word_q <= word;
            rd_bank_q <= bank;
         end
         if (cen) rsel_q <= s_bank;
      end
   for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      logic sel;
      assign sel = cen & (s_bank == BSW'(b));
      sram_sp_be #(.DW(DWIDTH), .AW(BANK_AW)) u_sram (
         .clk_i   (hclk),
         .cen_n_i (~sel),
         .wen_n_i (sel & we ? ~wr_mask_q : '1),
         .addr_i  (s_word),
         .wdata_i (bus.hwdata_i),
         .rdata_o (rdata[b])
      );
   end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed AHB-Lite transfers against ahb_sram_ctrl with hand-computed expectations.
module tb_ahb_sram_ctrl;
   import ahb_pkg::*;
   logic hclk = 1'b0;
   logic hresetn = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   ahb_sram_ctrl_if #(.AWIDTH(32), .DWIDTH(32)) bus ();
   assign bus.hready_i = bus.hreadyout_o;
   ahb_sram_ctrl #(.AWIDTH(32), .DWIDTH(32), .BANK_NUM(2), .BANK_AW(13)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );
   always #5 hclk = ~hclk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge hclk);
      #1;
   endtask
   task automatic addr_ph(input logic [1:0] tr, input logic w, input logic [2:0] sz, input logic [31:0] a);
      bus.hsel_i = 1'b1;
      bus.htrans_i = tr;
      bus.hwrite_i = w;
      bus.hsize_i = sz;
      bus.haddr_i = a;
   endtask
   task automatic idle;
      bus.htrans_i = HTRANS_IDLE;
      bus.hwrite_i = 1'b0;
   endtask
   task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      addr_ph(HTRANS_NONSEQ, 1'b1, sz, a);
      tick;
      idle;
      bus.hwdata_i = d;
      #4 chk("wr_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
   endtask
   task automatic rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] exp);
      addr_ph(HTRANS_NONSEQ, 1'b0, sz, a);
      tick;
      idle;
      #4 chk("rd_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("rd_data", bus.hrdata_o, exp);
      tick;
   endtask
   initial begin
      bus.hsel_i = 1'b0;
      bus.hwrite_i = 1'b0;
      bus.hsize_i = HSIZE_WORD;
      bus.hburst_i = HBURST_SINGLE;
      bus.htrans_i = HTRANS_IDLE;
      bus.hwdata_i = '0;
      bus.haddr_i = '0;
      repeat (2) @(posedge hclk);
      #4 chk("rst_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("rst_resp", 32'(bus.hresp_o), 32'd0);
      chk("rst_rdata", bus.hrdata_o, 32'd0);
      hresetn = 1'b1;
      tick;
      wr(HSIZE_WORD, 32'h10, 32'hDEADBEEF);
      #4 chk("idle_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
      rd(HSIZE_WORD, 32'h10, 32'hDEADBEEF);
      wr(HSIZE_WORD, 32'h10, 32'h11223344);
      wr(HSIZE_BYTE, 32'h13, 32'hAAFFFFFF);
      rd(HSIZE_WORD, 32'h10, 32'hAA223344);
      wr(HSIZE_HALF, 32'h10, 32'hFFFF5566);
      rd(HSIZE_WORD, 32'h10, 32'hAA225566);
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
      tick;
      bus.hwdata_i = 32'h12345678;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
      #4 chk("raw_wr_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
      #4 chk("raw_wait", 32'(bus.hreadyout_o), 32'd0);
      chk("raw_wait_data", bus.hrdata_o, 32'd0);
      tick;
      idle;
      #4 chk("raw_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("raw_data", bus.hrdata_o, 32'h12345678);
      tick;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      bus.hsel_i = 1'b0;
      tick;
      idle;
      #4 chk("nosel_data", bus.hrdata_o, 32'd0);
      tick;
      wr(HSIZE_WORD, 32'h0, 32'hCAFE0000);
      bus.hburst_i = HBURST_INCR4;
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000);
      tick;
      for (int i = 1; i <= 4; i++) begin
         if (i < 4) addr_ph(HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h8000 + 32'(4 * i));
         else idle;
         bus.hwdata_i = 32'hB0B00000 + 32'(i - 1);
         #4 chk("bw_rdy", 32'(bus.hreadyout_o), 32'd1);
         tick;
      end
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000);
      tick;
      addr_ph(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8004);
      #4 chk("br0", bus.hrdata_o, 32'hB0B00000);
      chk("br0_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
      addr_ph(HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h8008);
      #4 chk("br1", bus.hrdata_o, 32'hB0B00001);
      tick;
      addr_ph(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8008);
      #4 chk("busy_data", bus.hrdata_o, 32'd0);
      chk("busy_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("busy_resp", 32'(bus.hresp_o), 32'd0);
      tick;
      addr_ph(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h800C);
      #4 chk("br2", bus.hrdata_o, 32'hB0B00002);
      tick;
      idle;
      #4 chk("br3", bus.hrdata_o, 32'hB0B00003);
      chk("br3_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
      bus.hburst_i = HBURST_SINGLE;
      rd(HSIZE_WORD, 32'h0, 32'hCAFE0000);
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h1);
      tick;
      idle;
`ifdef AHB_SRAM_ERR_EN
      #4 chk("err1_resp", 32'(bus.hresp_o), 32'd1);
      chk("err1_rdy", 32'(bus.hreadyout_o), 32'd0);
      tick;
      #4 chk("err2_resp", 32'(bus.hresp_o), 32'd1);
      chk("err2_rdy", 32'(bus.hreadyout_o), 32'd1);
      tick;
      #4 chk("err_end_resp", 32'(bus.hresp_o), 32'd0);
      tick;
`else
      #4 chk("mis_resp", 32'(bus.hresp_o), 32'd0);
      chk("mis_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("mis_data", bus.hrdata_o, 32'hCAFE0000);
      tick;
`endif
      wr(HSIZE_WORD, 32'h30, 32'h77777777);
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
      tick;
      idle;
      bus.hwdata_i = 32'h99999999;
      hresetn = 1'b0;
      #1 chk("mid_rst_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("mid_rst_resp", 32'(bus.hresp_o), 32'd0);
      chk("mid_rst_rdata", bus.hrdata_o, 32'd0);
      tick;
      hresetn = 1'b1;
      tick;
      rd(HSIZE_WORD, 32'h30, 32'h77777777);
      chk("post_rst_resp", 32'(bus.hresp_o), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
